monkey_hit_detector: RTL and testbench
======================================

# monkey_hit_detector

Per-pixel collision detector that produces the collision inputs of the monkey movement block. It watches the monkey, wall and ladder drawing requests as the VGA scan passes and classifies each overlap pixel by which monkey sprite edge it lies on. It accumulates hits over one frame and, at the next start of frame, presents a one-cycle collision pulse plus a frame-stable edge code. It sits between the sprite/background drawers and the monkey movement logic.

## Interface
Parameters:
- OBJECT_WIDTH, 64: monkey sprite width in pixels.
- OBJECT_HEIGHT, 64: monkey sprite height in pixels.
- EDGE_MARGIN, 4: depth in pixels of each edge band.
- MIN_HIT_PIXELS, 2: minimum overlapping pixels per frame before a wall collision is reported.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- startOfFrame, in, 1: one-cycle pulse at the start of each frame.
- monkeyDR, in, 1: the monkey sprite draws this pixel.
- offsetX, in, 11: pixel X offset inside the monkey sprite. Valid when monkeyDR is high.
- offsetY, in, 11: pixel Y offset inside the monkey sprite. Valid when monkeyDR is high.
- wallDR, in, 1: a wall or platform draws this pixel.
- ladderDR, in, 1: a ladder draws this pixel.
- wallCollision, out, 1: one-cycle pulse per frame.
- ladderCollision, out, 1: one-cycle pulse per frame.
- HitEdgeCode, out, 4: edge code held for the whole frame. Bit 3 is left, bit 2 top, bit 1 right, bit 0 bottom.

## Operation
- States:
  - WAIT_SOF: entered on reset. Discards the partial frame.
  - ACCUM: entered on the first startOfFrame and stays there.
- Wall hit pixel: monkeyDR && wallDR while in ACCUM.
  - Increments hitCount, a 7-bit counter that saturates at 127.
  - ORs the classified edge bits into edgeAcc.
- Edge classification per pixel; any combination of bits may be set:
  - left: offsetX < EDGE_MARGIN
  - right: offsetX >= OBJECT_WIDTH-EDGE_MARGIN
  - top: offsetY < EDGE_MARGIN
  - bottom: offsetY >= OBJECT_HEIGHT-EDGE_MARGIN
  - A hit pixel in the interior sets no edge bit but still counts toward hitCount.
- Ladder hit pixel: monkeyDR && ladderDR in ACCUM. Sets ladderAcc.
- On startOfFrame while in ACCUM, the block commits the finished frame:
  - wallCollision pulses if hitCount >= MIN_HIT_PIXELS.
  - HitEdgeCode <= edgeAcc if that condition holds, else 4'b0000.
  - ladderCollision pulses if ladderAcc is set.
  - The accumulators clear.
- Simultaneous startOfFrame and hit pixel: that pixel belongs to the new frame. The accumulators load that pixel's contribution instead of clearing to zero.
- startOfFrame while in WAIT_SOF: the block goes to ACCUM with no output pulse.
- Reset mid-frame:
  - All outputs go to 0 and all accumulators clear.
  - The block returns to WAIT_SOF.

## Timing
- Reset values: wallCollision=0, ladderCollision=0, HitEdgeCode=4'b0000, state=WAIT_SOF.
- Latency: wallCollision and ladderCollision are high exactly on the cycle after startOfFrame. They are never high on any other cycle.
- HitEdgeCode updates on that same cycle and holds until the next commit.
- Inputs are sampled on every cycle; pixel rate equals the clk rate. No back-pressure.
- hitCount saturates at 127 and never wraps.
- The offset comparisons are unsigned on 11 bits.

## Configuration
- MONKEY_HIT_LADDER_EN defined: ladder detection is compiled in as described above.
- Not defined:
  - ladderAcc and its logic are removed.
  - ladderCollision is tied to 0.
  - ladderDR is ignored.
- Wall behaviour is identical in both builds.

## Structure
- Package monkey_hit_pkg holds:
  - typedef edge_code_t (logic [3:0]).
  - Edge bit index constants: EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0.
  - State enum hit_state_t {WAIT_SOF, ACCUM}.
- Sub-module monkey_edge_classify: combinational. Maps offsetX and offsetY to edge_code_t using the width, height and margin parameters.
- The top level holds the FSM, the accumulators and the output registers.

## Test plan
- Reset, then pulse startOfFrame → no collision pulse and HitEdgeCode=0. In the following frame, 3 hit pixels at offset (1,30), then startOfFrame → wallCollision high for exactly 1 cycle after startOfFrame and HitEdgeCode=4'b1000.
- Single hit pixel at offset (62,63) in a frame (MIN_HIT_PIXELS=2) → no wallCollision and HitEdgeCode=0. Two such pixels → wallCollision pulses and HitEdgeCode=4'b0011.
- 200 interior hit pixels at (30,30) → wallCollision pulses and HitEdgeCode=0. No counter wrap is observed.
- Hit pixel at (1,1) on the same cycle as startOfFrame, plus one more at (1,1) later in the frame → the next commit gives HitEdgeCode=4'b1100. The current commit excludes that pixel.
- Ladder overlap of 1 pixel → ladderCollision pulses once after the next startOfFrame when MONKEY_HIT_LADDER_EN is defined. It stays 0 when the macro is undefined.
- Reset asserted mid-frame after 5 hit pixels → outputs are 0, and the next startOfFrame produces no pulse (WAIT_SOF).

Source files
------------

// File: rtl/monkey_hit_pkg.sv
// Shared types and constants for the monkey collision detector.
// Edge code bit order: left, top, right, bottom (MSB to LSB).
package monkey_hit_pkg;

    typedef logic [3:0] edge_code_t;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int         HIT_COUNT_W = 7;
    localparam logic [6:0] HIT_MAX     = 7'd127;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } hit_state_t;

endpackage

// File: rtl/monkey_edge_classify.sv
// Combinational map from a sprite pixel offset to the edge bands it lies in.
// Bands may overlap at corners, so several bits can be set at once.
module monkey_edge_classify
    import monkey_hit_pkg::*;
#(
    parameter int OBJECT_WIDTH  = 64,
    parameter int OBJECT_HEIGHT = 64,
    parameter int EDGE_MARGIN   = 4
) (
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    output edge_code_t  edgeCode
);

    localparam logic [10:0] MARGIN    = 11'(EDGE_MARGIN);
    localparam logic [10:0] RIGHT_LIM = 11'(OBJECT_WIDTH - EDGE_MARGIN);
    localparam logic [10:0] BOT_LIM   = 11'(OBJECT_HEIGHT - EDGE_MARGIN);

    always_comb begin
        edgeCode              = '0;
        edgeCode[EDGE_LEFT]   = (offsetX < MARGIN);
        edgeCode[EDGE_TOP]    = (offsetY < MARGIN);
        edgeCode[EDGE_RIGHT]  = (offsetX >= RIGHT_LIM);
        edgeCode[EDGE_BOTTOM] = (offsetY >= BOT_LIM);
    end

endmodule

// File: rtl/monkey_hit_detector.sv
// Frame-accumulating wall/ladder collision detector for the monkey sprite.
// Optional ladder detection is compiled in with MONKEY_HIT_LADDER_EN.
//
// state    | meaning
// WAIT_SOF | after reset; partial frame discarded until first startOfFrame
// ACCUM    | accumulating hits; each startOfFrame commits the finished frame
module monkey_hit_detector
    import monkey_hit_pkg::*;
#(
    parameter int OBJECT_WIDTH   = 64,
    parameter int OBJECT_HEIGHT  = 64,
    parameter int EDGE_MARGIN    = 4,
    parameter int MIN_HIT_PIXELS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        monkeyDR,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        wallDR,
    input  logic        ladderDR,
    output logic        wallCollision,
    output logic        ladderCollision,
    output edge_code_t  HitEdgeCode
);

    hit_state_t             state, state_nxt;
    edge_code_t             pix_edge;
    edge_code_t             edge_acc, edge_acc_nxt;
    logic [HIT_COUNT_W-1:0] hit_count, hit_count_nxt;
    logic                   wall_hit;
    logic                   commit;
    logic                   wall_ok;

    monkey_edge_classify #(
        .OBJECT_WIDTH (OBJECT_WIDTH),
        .OBJECT_HEIGHT(OBJECT_HEIGHT),
        .EDGE_MARGIN  (EDGE_MARGIN)
    ) u_classify (
        .offsetX (offsetX),
        .offsetY (offsetY),
        .edgeCode(pix_edge)
    );

    assign wall_hit = monkeyDR && wallDR;
    assign commit   = (state == ACCUM) && startOfFrame;
    assign wall_ok  = (int'(hit_count) >= MIN_HIT_PIXELS);

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else       state <= state_nxt;
    end

    // A hit on the startOfFrame cycle seeds the new frame rather than the old one.
    always_comb begin
        state_nxt     = state;
        hit_count_nxt = hit_count;
        edge_acc_nxt  = edge_acc;
        if (startOfFrame) begin
            state_nxt     = ACCUM;
            hit_count_nxt = wall_hit ? HIT_COUNT_W'(1) : '0;
            edge_acc_nxt  = wall_hit ? pix_edge : '0;
        end else if ((state == ACCUM) && wall_hit) begin
            if (hit_count != HIT_MAX) hit_count_nxt = hit_count + HIT_COUNT_W'(1);
            edge_acc_nxt = edge_acc | pix_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count     <= '0;
            edge_acc      <= '0;
            wallCollision <= 1'b0;
            HitEdgeCode   <= '0;
        end else begin
            hit_count     <= hit_count_nxt;
            edge_acc      <= edge_acc_nxt;
            wallCollision <= commit && wall_ok;
            if (commit) HitEdgeCode <= wall_ok ? edge_acc : '0;
        end
    end

`ifdef MONKEY_HIT_LADDER_EN
    logic ladder_acc;
    logic ladder_hit;

    assign ladder_hit = monkeyDR && ladderDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            ladder_acc      <= 1'b0;
            ladderCollision <= 1'b0;
        end else begin
            ladderCollision <= commit && ladder_acc;
            if (startOfFrame)                        ladder_acc <= ladder_hit;
            else if ((state == ACCUM) && ladder_hit) ladder_acc <= 1'b1;
        end
    end
`else
    logic unused_ladder;
    assign unused_ladder   = ladderDR;
    assign ladderCollision = 1'b0;
`endif

endmodule

// File: tb/tb_monkey_hit_detector.sv
// Vector bench for monkey_hit_detector: each record is applied for one clock
// and the registered outputs are compared just after that edge.
module tb_monkey_hit_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        monkeyDR;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        wallDR;
    logic        ladderDR;
    logic        wallCollision;
    logic        ladderCollision;
    logic [3:0]  HitEdgeCode;

`ifdef MONKEY_HIT_LADDER_EN
    localparam logic LAD = 1'b1;
`else
    localparam logic LAD = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        sof;
        logic        mdr;
        logic        wdr;
        logic        ldr;
        logic [10:0] ox;
        logic [10:0] oy;
        logic        ew;
        logic        el;
        logic [3:0]  ec;
        int          phase;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    monkey_hit_detector #(
        .OBJECT_WIDTH  (64),
        .OBJECT_HEIGHT (64),
        .EDGE_MARGIN   (4),
        .MIN_HIT_PIXELS(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .monkeyDR       (monkeyDR),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .wallDR         (wallDR),
        .ladderDR       (ladderDR),
        .wallCollision  (wallCollision),
        .ladderCollision(ladderCollision),
        .HitEdgeCode    (HitEdgeCode)
    );

    task automatic add(input int ph, input logic rst, input logic sof, input logic mdr,
                       input logic wdr, input logic ldr, input int ox, input int oy,
                       input logic ew, input logic el, input logic [3:0] ec);
        vec_t v;
        v.phase = ph; v.rst = rst; v.sof = sof; v.mdr = mdr; v.wdr = wdr; v.ldr = ldr;
        v.ox = 11'(ox); v.oy = 11'(oy); v.ew = ew; v.el = el; v.ec = ec;
        vecs.push_back(v);
    endtask

    // Shorthands: idle cycle, wall hit pixel, startOfFrame (optionally with a hit).
    task automatic idle(input int ph, input logic [3:0] ec);
        add(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec);
    endtask
    task automatic hit(input int ph, input int ox, input int oy, input logic [3:0] ec);
        add(ph, 0, 0, 1, 1, 0, ox, oy, 0, 0, ec);
    endtask
    task automatic sof(input int ph, input logic ew, input logic el, input logic [3:0] ec);
        add(ph, 0, 1, 0, 0, 0, 0, 0, ew, el, ec);
    endtask

    initial begin
        // phase 0: reset, first startOfFrame gives no pulse
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 4'h0);
        sof(0, 0, 0, 4'h0);
        // phase 1: 3 left-edge hits
        for (int i = 0; i < 3; i++) hit(1, 1, 30, 4'h0);
        sof(1, 1, 0, 4'h8);
        idle(1, 4'h8);
        // phase 2: below threshold, then at threshold (right+bottom corner)
        hit(2, 62, 63, 4'h8);
        sof(2, 0, 0, 4'h0);
        hit(2, 62, 63, 4'h0);
        hit(2, 62, 63, 4'h0);
        sof(2, 1, 0, 4'h3);
        idle(2, 4'h3);
        // phase 3: 200 interior hits, then 128 (a 7-bit wrap would give 0 here)
        for (int i = 0; i < 200; i++) hit(3, 30, 30, 4'h3);
        sof(3, 1, 0, 4'h0);
        for (int i = 0; i < 128; i++) hit(3, 30, 30, 4'h0);
        sof(3, 1, 0, 4'h0);
        idle(3, 4'h0);
        // phase 4: hit on the startOfFrame cycle belongs to the new frame
        hit(4, 30, 30, 4'h0);
        hit(4, 30, 30, 4'h0);
        add(4, 0, 1, 1, 1, 0, 1, 1, 1, 0, 4'h0);
        hit(4, 1, 1, 4'h0);
        sof(4, 1, 0, 4'hC);
        idle(4, 4'hC);
        // phase 5: one ladder pixel, no wall; ladder pixel without monkey ignored
        add(5, 0, 0, 1, 0, 1, 30, 30, 0, 0, 4'hC);
        add(5, 0, 0, 0, 1, 1, 1, 1, 0, 0, 4'hC);
        sof(5, 0, LAD, 4'h0);
        idle(5, 4'h0);
        sof(5, 0, 0, 4'h0);
        // phase 6: committed code, then reset mid-frame after 5 hits
        hit(6, 1, 1, 4'h0);
        hit(6, 1, 1, 4'h0);
        sof(6, 1, 0, 4'hC);
        for (int i = 0; i < 5; i++) hit(6, 1, 1, 4'hC);
        add(6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        idle(6, 4'h0);
        sof(6, 0, 0, 4'h0);
        hit(6, 62, 63, 4'h0);
        hit(6, 62, 63, 4'h0);
        sof(6, 1, 0, 4'h3);
        idle(6, 4'h3);

        reset = 1'b1; startOfFrame = 0; monkeyDR = 0; wallDR = 0; ladderDR = 0;
        offsetX = '0; offsetY = '0;
        @(posedge clk); #1;

        checks++;
        if (wallCollision !== 1'b0 || ladderCollision !== 1'b0 || HitEdgeCode !== 4'h0) begin
            errors++;
            $display("FAIL reset state: got wall=%b ladder=%b code=%b",
                     wallCollision, ladderCollision, HitEdgeCode);
        end

        foreach (vecs[i]) begin
            reset        = vecs[i].rst;
            startOfFrame = vecs[i].sof;
            monkeyDR     = vecs[i].mdr;
            wallDR       = vecs[i].wdr;
            ladderDR     = vecs[i].ldr;
            offsetX      = vecs[i].ox;
            offsetY      = vecs[i].oy;
            @(posedge clk); #1;
            checks++;
            if (wallCollision !== vecs[i].ew || ladderCollision !== vecs[i].el ||
                HitEdgeCode !== vecs[i].ec) begin
                errors++;
                $display("FAIL vec%0d phase%0d: got wall=%b ladder=%b code=%b, want wall=%b ladder=%b code=%b",
                         i, vecs[i].phase, wallCollision, ladderCollision, HitEdgeCode,
                         vecs[i].ew, vecs[i].el, vecs[i].ec);
            end
        end

        reset = 1'b0; startOfFrame = 0; monkeyDR = 0; wallDR = 0; ladderDR = 0;
        offsetX = '0; offsetY = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wallCollision !== 1'b0 || ladderCollision !== 1'b0 || HitEdgeCode !== 4'h3) begin
            errors++;
            $display("FAIL expired wait: got wall=%b ladder=%b code=%b, want wall=0 ladder=0 code=0011",
                     wallCollision, ladderCollision, HitEdgeCode);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
